// File: rtl/vga_timing_prog.sv
// Programmable VGA raster timing generator with shadowed timing registers.
// Optional raster-line interrupt: define VGA_TIMING_LINE_IRQ_EN.
module vga_timing_prog #(
    parameter int XW        = 11,
    parameter int YW        = 10,
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int ROW_H     = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_sel,
    input  logic [11:0]              cfg_data,
    output logic [XW-1:0]            x,
    output logic [YW-1:0]            y,
    output logic [YW-1:0]            y_row,
    output logic [$clog2(ROW_H)-1:0] y_sub,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     blank,
    output logic                     line_start,
    output logic                     frame_start,
    output logic                     line_irq
);

    localparam int SW = $clog2(ROW_H);

    localparam logic [3:0][XW-1:0] RST_H = {
        XW'(H_BP), XW'(H_SYNC), XW'(H_FP), XW'(H_ACTIVE)
    };
    localparam logic [3:0][YW-1:0] RST_V = {
        YW'(V_BP), YW'(V_SYNC), YW'(V_FP), YW'(V_ACTIVE)
    };
    localparam logic [XW-1:0] RST_H_SS  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] RST_H_SE  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] RST_H_TOT = XW'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [YW-1:0] RST_V_SS  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] RST_V_SE  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] RST_V_TOT = YW'(V_ACTIVE + V_FP + V_SYNC + V_BP);

    // Shadow fields, index 0..3 = active/fp/sync/bp.
    logic [3:0][XW-1:0] sh_h_q, sh_h_d;
    logic [3:0][YW-1:0] sh_v_q, sh_v_d;

    // Active timing, kept as precomputed boundaries.
    logic [XW-1:0] h_act_q, h_ss_q, h_se_q, h_tot_q;
    logic [YW-1:0] v_act_q, v_ss_q, v_se_q, v_tot_q;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [YW-1:0] row_q, row_d;
    logic [SW-1:0] sub_q, sub_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;

    logic [XW-1:0] wr_h;
    logic [YW-1:0] wr_v;
    logic [XW-1:0] nh_ss, nh_se, nh_tot;
    logic [YW-1:0] nv_ss, nv_se, nv_tot;
    logic          x_wrap, y_wrap, frame_end;
    logic          unused_cfg;

    assign unused_cfg = ^cfg_data;

    assign x_wrap    = (x_q == h_tot_q - XW'(1));
    assign y_wrap    = (y_q == v_tot_q - YW'(1));
    assign frame_end = x_wrap & y_wrap;

    // Boundaries derived from the shadow set, loaded at frame end.
    assign nh_ss  = sh_h_q[0] + sh_h_q[1];
    assign nh_se  = nh_ss + sh_h_q[2];
    assign nh_tot = nh_se + sh_h_q[3];
    assign nv_ss  = sh_v_q[0] + sh_v_q[1];
    assign nv_se  = nv_ss + sh_v_q[2];
    assign nv_tot = nv_se + sh_v_q[3];

    // Shadow write path; a zero field would stall the raster, so store 1.
    always_comb begin
        wr_h   = XW'(cfg_data);
        wr_v   = YW'(cfg_data);
        sh_h_d = sh_h_q;
        sh_v_d = sh_v_q;
        if (wr_h == '0) wr_h = XW'(1);
        if (wr_v == '0) wr_v = YW'(1);
        if (cfg_we && cfg_sel[3:2] == 2'b00) sh_h_d[cfg_sel[1:0]] = wr_h;
        if (cfg_we && cfg_sel[3:2] == 2'b01) sh_v_d[cfg_sel[1:0]] = wr_v;
    end

    // Shadow registers and atomic active-set load at frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_h_q  <= RST_H;
            sh_v_q  <= RST_V;
            h_act_q <= XW'(H_ACTIVE);
            h_ss_q  <= RST_H_SS;
            h_se_q  <= RST_H_SE;
            h_tot_q <= RST_H_TOT;
            v_act_q <= YW'(V_ACTIVE);
            v_ss_q  <= RST_V_SS;
            v_se_q  <= RST_V_SE;
            v_tot_q <= RST_V_TOT;
        end else begin
            sh_h_q <= sh_h_d;
            sh_v_q <= sh_v_d;
            if (frame_end) begin
                h_act_q <= sh_h_q[0];
                h_ss_q  <= nh_ss;
                h_se_q  <= nh_se;
                h_tot_q <= nh_tot;
                v_act_q <= sh_v_q[0];
                v_ss_q  <= nv_ss;
                v_se_q  <= nv_se;
                v_tot_q <= nv_tot;
            end
        end
    end

    // Next raster position and row/sub-row split without a divider.
    always_comb begin
        x_d   = x_q + XW'(1);
        y_d   = y_q;
        row_d = row_q;
        sub_d = sub_q;
        if (x_wrap) begin
            x_d = '0;
            if (y_wrap) begin
                y_d   = '0;
                row_d = '0;
                sub_d = '0;
            end else begin
                y_d = y_q + YW'(1);
                if (sub_q == SW'(ROW_H - 1)) begin
                    sub_d = '0;
                    row_d = row_q + YW'(1);
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end
        end
        hs_d = ((x_q >= h_ss_q) && (x_q < h_se_q)) ? HSYNC_POL : ~HSYNC_POL;
        vs_d = ((y_q >= v_ss_q) && (y_q < v_se_q)) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Raster counters and registered sync outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            row_q <= '0;
            sub_q <= '0;
            hs_q  <= ~HSYNC_POL;
            vs_q  <= ~VSYNC_POL;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            row_q <= row_d;
            sub_q <= sub_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    logic [YW-1:0] irq_sh_q, irq_sh_d, irq_act_q;
    logic          irq_q;

    // Raster-line compare value is written to shadow only.
    always_comb begin
        irq_sh_d = irq_sh_q;
        if (cfg_we && cfg_sel == 4'd8) irq_sh_d = YW'(cfg_data);
    end

    // Interrupt line register set and one-cycle pulse at line start.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_sh_q  <= '0;
            irq_act_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irq_sh_q <= irq_sh_d;
            if (frame_end) irq_act_q <= irq_sh_q;
            irq_q <= (x_q == '0) && (y_q == irq_act_q);
        end
    end

    assign line_irq = irq_q;
`else
    assign line_irq = 1'b0;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign y_row       = row_q;
    assign y_sub       = sub_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign blank       = (x_q >= h_act_q) | (y_q >= v_act_q);
    assign line_start  = ~rst & (x_q == '0);
    assign frame_start = ~rst & (x_q == '0) & (y_q == '0);

endmodule

// File: tb/tb_vga_timing_prog.sv
// Testbench for vga_timing_prog: hand vectors, directed frames, random cfg.
// Honours VGA_TIMING_LINE_IRQ_EN for line_irq expectations.
module tb_vga_timing_prog;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int RH = 2;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_sel = '0;
    logic [11:0]   cfg_data = '0;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] y_row;
    logic [0:0]    y_sub;
    logic          hsync, vsync, blank;
    logic          line_start, frame_start, line_irq;

    vga_timing_prog #(
        .XW(XW), .YW(YW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .ROW_H(RH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .x(x), .y(y), .y_row(y_row), .y_sub(y_sub),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .line_start(line_start), .frame_start(frame_start),
        .line_irq(line_irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: position in frame as a flat cycle index.
    int act[9];
    int sh[9];
    int t = 0;
    bit hs_e = ~HP;
    bit vs_e = ~VP;
    bit irq_e = 1'b0;

    typedef struct {
        logic r;
        int   ex;
        int   ey;
        int   eb;
        int   ehs;
        int   els;
    } vec_t;
    vec_t tbl[18];

    function automatic int htot();
        return act[0] + act[1] + act[2] + act[3];
    endfunction

    function automatic int vtot();
        return act[4] + act[5] + act[6] + act[7];
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, got, exp, $time);
    endtask

    task automatic model_reset();
        act = '{HA, HF, HS, HB, VA, VF, VS, VB, 0};
        sh  = act;
        t   = 0;
        hs_e  = ~HP;
        vs_e  = ~VP;
        irq_e = 1'b0;
    endtask

    task automatic model_edge();
        int x0, y0, v;
        int old_sh[9];
        if (rst) begin
            model_reset();
            return;
        end
        x0 = t % htot();
        y0 = t / htot();
        hs_e = (x0 >= act[0] + act[1] && x0 < act[0] + act[1] + act[2])
               ? HP : ~HP;
        vs_e = (y0 >= act[4] + act[5] && y0 < act[4] + act[5] + act[6])
               ? VP : ~VP;
        irq_e = IRQ && x0 == 0 && y0 == act[8];
        old_sh = sh;
        if (cfg_we) begin
            if (cfg_sel < 4) begin
                v = int'(cfg_data) % (1 << XW);
                sh[cfg_sel] = (v == 0) ? 1 : v;
            end else if (cfg_sel < 8) begin
                v = int'(cfg_data) % (1 << YW);
                sh[cfg_sel] = (v == 0) ? 1 : v;
            end else if (cfg_sel == 8 && IRQ) begin
                sh[8] = int'(cfg_data) % (1 << YW);
            end
        end
        t++;
        if (t == htot() * vtot()) begin
            t   = 0;
            act = old_sh;
        end
    endtask

    task automatic check_all();
        int ex, ey;
        ex = t % htot();
        ey = t / htot();
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("y_row", int'(y_row), ey / RH);
        chk("y_sub", int'(y_sub), ey % RH);
        chk("hsync", int'(hsync), int'(hs_e));
        chk("vsync", int'(vsync), int'(vs_e));
        chk("blank", int'(blank), int'(ex >= act[0] || ey >= act[4]));
        chk("line_start", int'(line_start), int'(!rst && ex == 0));
        chk("frame_start", int'(frame_start),
            int'(!rst && ex == 0 && ey == 0));
        chk("line_irq", int'(line_irq), int'(irq_e));
    endtask

    task automatic step(input logic r, input logic we,
                        input logic [3:0] sel, input logic [11:0] d);
        rst      = r;
        cfg_we   = we;
        cfg_sel  = sel;
        cfg_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Runs to the next frame_start, gathering per-frame statistics.
    task automatic wait_frame(output int n, output int hl, output int vl,
                              output int ic, output int ip);
        n = 2001; hl = 0; vl = 0; ic = 0; ip = -1;
        for (int i = 1; i <= 2000; i++) begin
            step(1'b0, 1'b0, 4'd0, 12'd0);
            if (!hsync) hl++;
            if (!vsync) vl++;
            if (line_irq) begin
                ic++;
                if (ip < 0) ip = i;
            end
            if (frame_start) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int n, hl, vl, ic, ip;
        logic [3:0] s;
        logic [11:0] d;

        tbl[0]  = '{1'b0,  1, 0, 0, 1, 0};
        tbl[1]  = '{1'b0,  2, 0, 0, 1, 0};
        tbl[2]  = '{1'b0,  3, 0, 0, 1, 0};
        tbl[3]  = '{1'b0,  4, 0, 0, 1, 0};
        tbl[4]  = '{1'b0,  5, 0, 0, 1, 0};
        tbl[5]  = '{1'b0,  6, 0, 0, 1, 0};
        tbl[6]  = '{1'b0,  7, 0, 0, 1, 0};
        tbl[7]  = '{1'b0,  8, 0, 1, 1, 0};
        tbl[8]  = '{1'b0,  9, 0, 1, 1, 0};
        tbl[9]  = '{1'b0, 10, 0, 1, 1, 0};
        tbl[10] = '{1'b0, 11, 0, 1, 0, 0};
        tbl[11] = '{1'b0, 12, 0, 1, 0, 0};
        tbl[12] = '{1'b0, 13, 0, 1, 0, 0};
        tbl[13] = '{1'b0, 14, 0, 1, 1, 0};
        tbl[14] = '{1'b0, 15, 0, 1, 1, 0};
        tbl[15] = '{1'b0,  0, 1, 0, 1, 1};
        tbl[16] = '{1'b0,  1, 1, 0, 1, 0};
        tbl[17] = '{1'b1,  0, 0, 0, 1, 0};

        model_reset();
        step(1'b1, 1'b0, 4'd0, 12'd0);
        step(1'b1, 1'b0, 4'd0, 12'd0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);

        rst = 1'b0;
        #1;
        chk("first_x", int'(x), 0);
        chk("first_frame_start", int'(frame_start), 1);
        chk("first_line_start", int'(line_start), 1);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, 1'b0, 4'd0, 12'd0);
            chk("tbl_x", int'(x), tbl[i].ex);
            chk("tbl_y", int'(y), tbl[i].ey);
            chk("tbl_blank", int'(blank), tbl[i].eb);
            chk("tbl_hsync", int'(hsync), tbl[i].ehs);
            chk("tbl_line_start", int'(line_start), tbl[i].els);
        end

        wait_frame(n, hl, vl, ic, ip);
        chk("period_reset", n, 128);
        chk("hs_low_reset", hl, 24);
        chk("vs_low_reset", vl, 32);

        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'd0, 12'd0);
        step(1'b0, 1'b1, 4'd0, 12'd4);
        wait_frame(n, hl, vl, ic, ip);
        chk("period_before_hact", n, 128 - 21);
        wait_frame(n, hl, vl, ic, ip);
        chk("period_hact4", n, 96);
        chk("hs_low_hact4", hl, 24);
        chk("vs_low_hact4", vl, 24);

        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 4'd0, 12'd0);
        step(1'b0, 1'b1, 4'd2, 12'd0);
        wait_frame(n, hl, vl, ic, ip);
        chk("wait_hsync0", int'(n <= 2000), 1);
        wait_frame(n, hl, vl, ic, ip);
        chk("period_hsync0", n, 80);
        chk("hs_low_hsync0", hl, 8);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 12'd0);
        step(1'b0, 1'b1, 4'd8, 12'd3);
        wait_frame(n, hl, vl, ic, ip);
        chk("wait_irq", int'(n <= 2000), 1);
        wait_frame(n, hl, vl, ic, ip);
        chk("irq_count", ic, IRQ ? 1 : 0);
        chk("irq_pos", ip, IRQ ? 31 : -1);

        n = 0;
        while (n < 1000 && t != htot() * vtot() - 1) begin
            step(1'b0, 1'b0, 4'd0, 12'd0);
            n++;
        end
        chk("reach_boundary", int'(n < 1000), 1);
        step(1'b0, 1'b1, 4'd0, 12'd6);
        chk("boundary_frame_start", int'(frame_start), 1);
        wait_frame(n, hl, vl, ic, ip);
        chk("period_after_bwrite", n, 80);
        wait_frame(n, hl, vl, ic, ip);
        chk("period_hact6", n, 96);

        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'd0, 12'd0);
        step(1'b1, 1'b0, 4'd0, 12'd0);
        chk("midrst_x", int'(x), 0);
        chk("midrst_hsync", int'(hsync), 1);
        chk("midrst_line_irq", int'(line_irq), 0);

        for (int i = 0; i < 4000; i++) begin
            s = 4'($urandom_range(0, 15));
            if (s < 4) d = 12'($urandom_range(0, 5));
            else if (s < 8) d = 12'($urandom_range(0, 3));
            else if (s == 8) d = 12'($urandom_range(0, 12));
            else d = 12'($urandom);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 s, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
